bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 27, binary input width.
REQ-002 SHALL have parameter NDIG, default 8, BCD digits on output (4*NDIG = 32 bits, matching the seven-segment display's 32-bit input).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request conversion of bin; sampled each rising edge.
REQ-006 SHALL have port bin  input  BIN_W  unsigned binary value; sampled only on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new, valid bcd value.
REQ-009 SHALL have port overflow  output  1  last accepted bin exceeded 10^NDIG-1; held until the next accepted start.
REQ-010 SHALL have port bcd  output  4*NDIG  packed BCD, digit 0 in [3:0], digit 7 in [31:28]; feeds display input directly.

Function
REQ-011 SHALL implement the FSM states IDLE and SHIFT.
REQ-012 SHALL accept start only in IDLE; this includes the cycle in which done is high, giving back-to-back conversions.
REQ-013 SHALL ignore start in SHIFT, with no effect on the running conversion.
REQ-014 SHALL, on an accepted start with bin <= 10^NDIG-1 (edge E0), latch bin into the shift register, clear the scratch BCD register, clear overflow, set busy=1, and go to SHIFT.
REQ-015 SHALL, in SHIFT, perform one double-dabble step per edge: each scratch digit >= 5 gets +3, then the combined {scratch, shift} register shifts left by 1.
REQ-016 SHALL perform exactly BIN_W steps, on edges E1..E_BIN_W, tracked by a step counter sized clog2(BIN_W+1).
REQ-017 SHALL, on edge E_BIN_W, load bcd with the result of the final step, pulse done=1 for one cycle, set busy=0, and return to IDLE; latency start->done is BIN_W cycles (27 at default).
REQ-018 SHALL, on an accepted start with bin > 10^NDIG-1 (edge E0), load bcd=all 1s (32'hFFFF_FFFF), set overflow=1 and done=1 for one cycle, keep busy=0, and stay in IDLE.
REQ-019 SHALL change bcd only on a done edge, so the downstream display never sees partial results; bcd holds its value otherwise.
REQ-020 SHALL give done precedence over nothing: done and a newly accepted start on the same edge are legal, and the new conversion's busy=1 appears on that edge.
REQ-021 SHALL never let a scratch digit exceed 9 after adjustment; every bcd nibble after a non-overflow done is 0..9.

Reset
REQ-022 SHALL, when clr=1 at a rising edge, set state=IDLE, busy=0, done=0, overflow=0, bcd=0, step counter=0, and scratch/shift registers=0.
REQ-023 SHALL let clr abort a conversion mid-SHIFT: no done pulse, and bcd=0.
REQ-024 SHALL let clr override start on the same edge, so start is not accepted.

Structure
REQ-025 SHALL place BIN_W, NDIG, the state enum (IDLE, SHIFT), and the constant OVF_PATTERN (all 1s) in shared package bcd_pkg.
REQ-026 SHALL use one sub-module, bcd_digit_adj: a 4-bit combinational add-3-if->=5 cell, instantiated NDIG times.
REQ-027 SHALL keep the top level to the FSM, counter, and registers; no latches, and all outputs are registered.

Verification
REQ-028 SHALL cover: start with bin=0 -> done exactly 27 cycles after start, bcd=32'h0000_0000, overflow=0.
REQ-029 SHALL cover: bin=12_345_678 -> bcd=32'h1234_5678 at done, busy high for 27 cycles, done high for 1 cycle.
REQ-030 SHALL cover: bin=99_999_999 -> bcd=32'h9999_9999; then bin=100_000_000 -> done 1 cycle after start, bcd=32'hFFFF_FFFF, overflow=1, busy never high.
REQ-031 SHALL cover: bin=42 started; start re-pulsed with bin=7 at cycle 10 -> ignored, result 32'h0000_0042; start held high through done -> next conversion (bin=7) accepted on the done edge, result 32'h0000_0007.
REQ-032 SHALL cover: bin=87_654_321 started; clr=1 at cycle 15 -> busy=0, bcd=0, no done pulse; a later start with bin=5 -> 32'h0000_0005.
REQ-033 SHALL cover: random bin in 0..99_999_999, 1000 iterations, checked against a reference decimal model; every nibble 0..9.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Digit count and width defaults match the seven-segment display front end.
package bcd_pkg;

    localparam int BIN_W = 27;
    localparam int NDIG  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [4*NDIG-1:0] OVF_PATTERN = '1;

    // Largest value representable in ndig decimal digits (10^ndig - 1).
    function automatic logic [63:0] max_dec(input int ndig);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < ndig; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, BIN_W clocks per
// conversion, with bcd updated only on the done edge so displays never glitch.
module bin2bcd_seq #(
    parameter int BIN_W = bcd_pkg::BIN_W,
    parameter int NDIG  = bcd_pkg::NDIG
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [4*NDIG-1:0]   bcd
);

    import bcd_pkg::*;

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    localparam logic [63:0] MAX_VAL = max_dec(NDIG);
    localparam logic [BCD_W-1:0] OVF_BCD = BCD_W'(OVF_PATTERN);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BCD_W-1:0]    scratch;
    logic [BIN_W-1:0]    shreg;
    logic [BCD_W-1:0]    adj;
    logic [BCD_W-1:0]    next_scratch;
    logic                too_big;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Shifting the adjusted digits left pulls in the next binary MSB.
    assign next_scratch = {adj[BCD_W-2:0], shreg[BIN_W-1]};
    assign too_big      = 64'(bin) > MAX_VAL;

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            cnt      <= '0;
            scratch  <= '0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (too_big) begin
                            bcd      <= OVF_BCD;
                            overflow <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            shreg    <= bin;
                            scratch  <= '0;
                            cnt      <= '0;
                            overflow <= 1'b0;
                            busy     <= 1'b1;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    shreg   <= {shreg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        bcd   <= next_scratch;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, hand-written corner
// sequences and a random sweep, all results checked through a scoreboard.
module tb_bin2bcd_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic [26:0] bin;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] bcd;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic        ovf;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    bin2bcd_seq dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd      (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Decimal reference model, independent of the shift-and-add algorithm.
    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Entered at the negedge after the accepting edge (cycle cyc0); returns at done's negedge.
    task automatic waitDone(input int exp_lat, input int cyc0, input string tag);
        int   cyc;
        int   busy_cnt;
        bit   seen;
        int   bad;
        exp_t e;
        cyc = cyc0;
        busy_cnt = 0;
        seen = 0;
        while (cyc <= 200) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            checkOutput({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
            checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - cyc0));
            if (sb.size() == 0) begin
                checkOutput({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({tag, "_bcd"}, 64'(bcd), 64'(e.bcd));
                checkOutput({tag, "_overflow"}, 64'(overflow), 64'(e.ovf));
                if (!e.ovf) begin
                    bad = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (bcd[4*i +: 4] > 4'd9) bad++;
                    end
                    checkOutput({tag, "_nibble_range"}, 64'(bad), 64'd0);
                end
            end
        end
    endtask

    // Starts one conversion from a negedge, waits for done, checks the pulse width.
    task automatic applyStimulus(input logic [26:0] b, input logic [31:0] exp_bcd,
                                 input logic exp_ovf, input int exp_lat, input string tag);
        exp_t e;
        logic [31:0] held;
        bin   = b;
        start = 1'b1;
        @(posedge clk);
        e.bcd = exp_bcd;
        e.ovf = exp_ovf;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        waitDone(exp_lat, 0, tag);
        held = bcd;
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_bcd_hold"}, 64'(bcd), 64'(held));
    endtask

    initial begin
        int   done_cnt;
        int   r;
        exp_t e;

        clr   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_bcd", 64'(bcd), 64'd0);
        clr = 1'b0;
        @(negedge clk);

        vecs[0] = '{27'd0,           32'h0000_0000, 1'b0, 27};
        vecs[1] = '{27'd12_345_678,  32'h1234_5678, 1'b0, 27};
        vecs[2] = '{27'd99_999_999,  32'h9999_9999, 1'b0, 27};
        vecs[3] = '{27'd100_000_000, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[4] = '{27'd1,           32'h0000_0001, 1'b0, 27};
        vecs[5] = '{27'd134_217_727, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[6] = '{27'd10,          32'h0000_0010, 1'b0, 27};
        vecs[7] = '{27'd9,           32'h0000_0009, 1'b0, 27};
        vecs[8] = '{27'd50_505_050,  32'h5050_5050, 1'b0, 27};
        vecs[9] = '{27'd90_000_001,  32'h9000_0001, 1'b0, 27};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Overflow case must never raise busy.
        bin   = 27'd100_000_000;
        start = 1'b1;
        @(posedge clk);
        e.bcd = 32'hFFFF_FFFF;
        e.ovf = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ovf_busy", 64'(busy), 64'd0);
        waitDone(0, 0, "ovf");
        @(negedge clk);

        // Re-pulsed start mid-conversion is ignored; held start is taken on the done cycle.
        bin   = 27'd42;
        start = 1'b1;
        @(posedge clk);
        e.bcd = 32'h0000_0042;
        e.ovf = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        bin   = 27'd7;
        start = 1'b1;
        waitDone(27, 10, "ignore42");
        e.bcd = 32'h0000_0007;
        e.ovf = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        checkOutput("b2b_done_low", 64'(done), 64'd0);
        checkOutput("b2b_bcd_hold", 64'(bcd), 64'h42);
        waitDone(27, 0, "b2b7");
        @(negedge clk);

        // Clear aborts a conversion: no done, bcd and busy cleared.
        bin   = 27'd87_654_321;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_bcd", 64'(bcd), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
        applyStimulus(27'd5, 32'h0000_0005, 1'b0, 27, "after_abort");

        // Clear beats start on the same edge.
        clr   = 1'b1;
        start = 1'b1;
        bin   = 27'd3;
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        checkOutput("clr_vs_start_busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("clr_vs_start_busy2", 64'(busy), 64'd0);
        checkOutput("clr_vs_start_done", 64'(done), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            r = int'($urandom_range(99_999_999, 0));
            applyStimulus(27'(r), to_bcd(r), 1'b0, 27, "rand");
        end

        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
